mdu_iterative: RTL

- Iterative RV32M multiply/divide unit in the EX stage.
- Its result feeds the writeback-select mux as one of the N-bit data inputs.
- Operands and operation are latched on a start handshake; the result is produced after a fixed, deterministic latency.
- The hazard logic stalls the pipeline while busy is high.

---
 rtl/mdu_iterative.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_iterative.sv
// Purpose:      iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Latency:      XLEN+1 cycles from accepted start to done; 1 cycle for divide special cases.
// Backpressure: none; start is taken only in IDLE and busy stalls the pipeline during RUN.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous active-high reset, overrides start_i and flush_i
//   start_i   request a new operation (sampled only in IDLE)
//   flush_i   abort the in-flight operation; no done pulse, result_o keeps its value
//   op_i      funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   rs1_i     operand A (multiplicand / dividend)
//   rs2_i     operand B (multiplier / divisor)
//   busy_o    high exactly while in RUN
//   done_o    one-cycle pulse, result_o valid in that cycle
//   result_o  registered result, held until the next done pulse
module mdu_iterative #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     opb_q, opb_d;        // multiplicand / divisor magnitude
   logic [2*XLEN-1:0]   prod_q, prod_d;      // {partial product, remaining multiplier}
   logic [XLEN:0]       rem_q, rem_d;        // partial remainder
   logic [XLEN-1:0]     quo_q, quo_d;        // dividend shifting out, quotient shifting in
   logic                neg_q, neg_d;        // final result must be negated
   logic                spec_q, spec_d;      // divide special case, result precomputed
   logic [XLEN-1:0]     spec_res_q, spec_res_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                done_q, done_d;

   // ------------------------------------------------------------------
   // Operand decode (used only when a start is accepted)
   // ------------------------------------------------------------------
   logic            a_signed, b_signed;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            is_div;
   logic            div_zero, div_ovf, special;
   logic [XLEN-1:0] spec_val;
   logic            neg_start;

   always_comb begin
      a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                 (op_i == OP_DIV)  || (op_i == OP_REM);
      b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
      a_neg    = a_signed & rs1_i[XLEN-1];
      b_neg    = b_signed & rs2_i[XLEN-1];
      a_mag    = a_neg ? (~rs1_i + 1'b1) : rs1_i;
      b_mag    = b_neg ? (~rs2_i + 1'b1) : rs2_i;
      is_div   = op_i[2];
      div_zero = (rs2_i == '0);
      div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (rs1_i == INT_MIN) && (rs2_i == '1);
      special  = is_div && (div_zero || div_ovf);
      // op_i[1] distinguishes remainder from quotient within the divide group.
      if (div_zero) begin
         spec_val = op_i[1] ? rs1_i : '1;
      end else begin
         spec_val = op_i[1] ? '0 : rs1_i;
      end
      // Remainder follows the dividend; product and quotient follow sign XOR.
      if (is_div && op_i[1]) begin
         neg_start = a_neg;
      end else begin
         neg_start = a_neg ^ b_neg;
      end
   end

   // ------------------------------------------------------------------
   // One iteration step
   // ------------------------------------------------------------------
   logic [XLEN:0]   mul_sum;
   logic [XLEN+1:0] rem_sh;
   logic [XLEN+1:0] rem_sub;
   logic            rem_ge;

   always_comb begin
      // Shift-add: add the multiplicand into the upper half when the
      // current multiplier LSB is set; the carry re-enters on the shift.
      mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                (prod_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
      // Restoring divide: bring down the next dividend bit and trial-subtract.
      // The shifted value never reaches bit XLEN+1, so that bit of the
      // difference is a clean borrow flag.
      rem_sh  = {rem_q, quo_q[XLEN-1]};
      rem_sub = rem_sh - {2'b00, opb_q};
      rem_ge  = ~rem_sub[XLEN+1];
   end

   // ------------------------------------------------------------------
   // Sign correction and result select, applied in DONE
   // ------------------------------------------------------------------
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   mul_res;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   final_res;

   always_comb begin
      prod_fix = neg_q ? (~prod_q + 1'b1) : prod_q;
      mul_res  = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      quo_fix  = neg_q ? (~quo_q + 1'b1) : quo_q;
      rem_fix  = neg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
      if (spec_q) begin
         final_res = spec_res_q;
      end else if (!op_q[2]) begin
         final_res = mul_res;
      end else if (op_q[1]) begin
         final_res = rem_fix;
      end else begin
         final_res = quo_fix;
      end
   end

   // ------------------------------------------------------------------
   // Next-state / datapath control
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      opb_d      = opb_q;
      prod_d     = prod_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      neg_d      = neg_q;
      spec_d     = spec_q;
      spec_res_d = spec_res_q;
      result_d   = result_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               op_d       = op_i;
               opb_d      = b_mag;
               prod_d     = {{XLEN{1'b0}}, a_mag};
               rem_d      = '0;
               quo_d      = a_mag;
               neg_d      = neg_start;
               spec_d     = special;
               spec_res_d = spec_val;
               cnt_d      = '0;
               state_d    = special ? S_DONE : S_RUN;
            end
         end

         S_RUN: begin
            if (flush_i) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (op_q[2]) begin
                  rem_d = rem_ge ? rem_sub[XLEN:0] : rem_sh[XLEN:0];
                  quo_d = {quo_q[XLEN-2:0], rem_ge};
               end else begin
                  prod_d = {mul_sum, prod_q[XLEN-1:1]};
               end
               if (cnt_q == LAST_ITER) begin
                  state_d = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            if (!flush_i) begin
               result_d = final_res;
               done_d   = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         op_q       <= '0;
         opb_q      <= '0;
         prod_q     <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         neg_q      <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         result_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         opb_q      <= opb_d;
         prod_q     <= prod_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         neg_q      <= neg_d;
         spec_q     <= spec_d;
         spec_res_q <= spec_res_d;
         result_q   <= result_d;
         done_q     <= done_d;
      end
   end

   assign busy_o   = (state_q == S_RUN);
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule
